// File: rtl/cpu_pkg.sv
// Shared definitions for the execute stage: default widths, decoded ALU opcodes,
// FSM state encoding and the packed flag record.
package cpu_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_OP_W   = 9;
  localparam int DEF_ADDR_W = 3;

  // Raw opcodes 0 and >= 15 collapse to OP_NOP during decode.
  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_NOT = 4'd6,
    OP_ADC = 4'd7,
    OP_SBB = 4'd8,
    OP_SHL = 4'd9,
    OP_SHR = 4'd10,
    OP_SAR = 4'd11,
    OP_ROL = 4'd12,
    OP_ROR = 4'd13,
    OP_RCL = 4'd14,
    OP_RSV = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WB    = 2'd2
  } state_e;

  typedef struct packed {
    logic z;
    logic c;
    logic s;
    logic v;
  } flags_t;

  function automatic logic is_alu_op(input alu_op_e op);
    return (op >= OP_ADD) && (op <= OP_SBB);
  endfunction

  function automatic logic is_shift_op(input alu_op_e op);
    return (op >= OP_SHL) && (op <= OP_RCL);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One-bit shift/rotate step used by the iterative shifter; RCL rotates the
// 9-bit quantity {carry, data}.
import cpu_pkg::*;

module alu_shift_step #(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] data_in,
  input  logic              carry_in,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] data_out,
  output logic              carry_out
);

  localparam int MSB = DATA_W - 1;

  always_comb begin
    data_out  = data_in;
    carry_out = carry_in;
    case (op)
      OP_SHL: begin
        data_out  = {data_in[MSB-1:0], 1'b0};
        carry_out = data_in[MSB];
      end
      OP_SHR: begin
        data_out  = {1'b0, data_in[MSB:1]};
        carry_out = data_in[0];
      end
      OP_SAR: begin
        data_out  = {data_in[MSB], data_in[MSB:1]};
        carry_out = data_in[0];
      end
      OP_ROL: begin
        data_out  = {data_in[MSB-1:0], data_in[MSB]};
        carry_out = data_in[MSB];
      end
      OP_ROR: begin
        data_out  = {data_in[0], data_in[MSB:1]};
        carry_out = data_in[0];
      end
      OP_RCL: begin
        data_out  = {data_in[MSB-1:0], carry_in};
        carry_out = data_in[MSB];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: single-cycle arithmetic/logic ops, iterative one-bit-per-cycle
// shifts, and a one-cycle register-file write-back with flag update.
import cpu_pkg::*;

module alu_exec_stage #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W   = DEF_OP_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [OP_W-1:0]   i_aluOp,
  input  logic [DATA_W-1:0] i_data1,
  input  logic [DATA_W-1:0] i_data2,
  input  logic [ADDR_W-1:0] i_addrRw,
  output logic [DATA_W-1:0] o_dataOut,
  output logic [ADDR_W-1:0] o_addrRw,
  output logic              o_rw,
  output logic              o_zeroFlag,
  output logic              o_carryFlag,
  output logic              o_signFlag,
  output logic              o_overflowFlag
);

  localparam int MSB = DATA_W - 1;

  state_e            state_reg, state_next;
  alu_op_e           op_reg, op_next;
  logic [DATA_W-1:0] work_reg, work_next;
  logic              shc_reg, shc_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  flags_t            flags_reg, flags_next;

  alu_op_e           op_dec;
  logic              accept;
  logic [2:0]        amt;
  logic [DATA_W:0]   sum_w;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_v;
  logic [DATA_W-1:0] step_data;
  logic              step_c;

  assign accept = i_valid && (state_reg == ST_IDLE);
  assign amt    = i_data2[2:0];
  assign op_dec = (i_aluOp < OP_W'(15)) ? alu_op_e'(i_aluOp[3:0]) : OP_NOP;

  // Single-cycle ALU evaluated directly on the offered operands; ADC/SBB take
  // the carry flag as it stands at the accept edge.
  always_comb begin
    sum_w   = '0;
    alu_res = '0;
    alu_c   = flags_reg.c;
    alu_v   = 1'b0;
    case (op_dec)
      OP_ADD, OP_ADC: begin
        sum_w   = {1'b0, i_data1} + {1'b0, i_data2}
                + {{DATA_W{1'b0}}, (op_dec == OP_ADC) && flags_reg.c};
        alu_res = sum_w[MSB:0];
        alu_c   = sum_w[DATA_W];
        alu_v   = (i_data1[MSB] == i_data2[MSB]) && (sum_w[MSB] != i_data1[MSB]);
      end
      OP_SUB, OP_SBB: begin
        sum_w   = {1'b0, i_data1} - {1'b0, i_data2}
                - {{DATA_W{1'b0}}, (op_dec == OP_SBB) && flags_reg.c};
        alu_res = sum_w[MSB:0];
        alu_c   = sum_w[DATA_W];
        alu_v   = (i_data1[MSB] != i_data2[MSB]) && (sum_w[MSB] != i_data1[MSB]);
      end
      OP_AND:  alu_res = i_data1 & i_data2;
      OP_OR:   alu_res = i_data1 | i_data2;
      OP_XOR:  alu_res = i_data1 ^ i_data2;
      OP_NOT:  alu_res = ~i_data1;
      default: ;
    endcase
  end

  alu_shift_step #(
    .DATA_W (DATA_W)
  ) u_shift_step (
    .data_in   (work_reg),
    .carry_in  (shc_reg),
    .op        (op_reg),
    .data_out  (step_data),
    .carry_out (step_c)
  );

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    work_next  = work_reg;
    shc_next   = shc_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    addr_next  = addr_reg;
    flags_next = flags_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          op_next = op_dec;
          if (is_alu_op(op_dec)) begin
            addr_next    = i_addrRw;
            data_next    = alu_res;
            flags_next.z = (alu_res == '0);
            flags_next.s = alu_res[MSB];
            flags_next.c = alu_c;
            flags_next.v = alu_v;
            state_next   = ST_WB;
          end else if (is_shift_op(op_dec)) begin
            addr_next = i_addrRw;
            if (amt == 3'd0) begin
              // Zero-length shift writes A back; carry and overflow stay put.
              data_next    = i_data1;
              flags_next.z = (i_data1 == '0);
              flags_next.s = i_data1[MSB];
              state_next   = ST_WB;
            end else begin
              work_next  = i_data1;
              shc_next   = flags_reg.c;
              cnt_next   = amt;
              state_next = ST_SHIFT;
            end
          end
        end
      end
      ST_SHIFT: begin
        work_next = step_data;
        shc_next  = step_c;
        cnt_next  = cnt_reg - 3'd1;
        if (cnt_reg == 3'd1) begin
          data_next    = step_data;
          flags_next.z = (step_data == '0);
          flags_next.s = step_data[MSB];
          flags_next.c = step_c;
          state_next   = ST_WB;
        end
      end
      ST_WB: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= ST_IDLE;
      op_reg    <= OP_NOP;
      work_reg  <= '0;
      shc_reg   <= 1'b0;
      cnt_reg   <= '0;
      data_reg  <= '0;
      addr_reg  <= '0;
      flags_reg <= '0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      work_reg  <= work_next;
      shc_reg   <= shc_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      addr_reg  <= addr_next;
      flags_reg <= flags_next;
    end
  end

  assign o_ready        = (state_reg == ST_IDLE);
  assign o_rw           = (state_reg == ST_WB);
  assign o_dataOut      = data_reg;
  assign o_addrRw       = addr_reg;
  assign o_zeroFlag     = flags_reg.z;
  assign o_carryFlag    = flags_reg.c;
  assign o_signFlag     = flags_reg.s;
  assign o_overflowFlag = flags_reg.v;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed vector table, handshake/reset sequences and
// random operations checked against an arithmetic reference model.
module tb_alu_exec_stage;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [8:0] i_aluOp = '0;
  logic [7:0] i_data1 = '0;
  logic [7:0] i_data2 = '0;
  logic [2:0] i_addrRw = '0;
  logic [7:0] o_dataOut;
  logic [2:0] o_addrRw;
  logic       o_rw;
  logic       o_zeroFlag, o_carryFlag, o_signFlag, o_overflowFlag;

  int checks = 0;
  int errors = 0;
  logic [3:0] m_flags = 4'b0000;  // model flags {Z,C,S,V}
  logic prev_rw = 1'b0;

  typedef struct {
    logic [8:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] addr;
    logic [7:0] res;
    logic [3:0] flags;
    int         lat;
  } vec_t;

  vec_t vecs[22];

  always #5 i_clk = ~i_clk;

  alu_exec_stage dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_aluOp        (i_aluOp),
    .i_data1        (i_data1),
    .i_data2        (i_data2),
    .i_addrRw       (i_addrRw),
    .o_dataOut      (o_dataOut),
    .o_addrRw       (o_addrRw),
    .o_rw           (o_rw),
    .o_zeroFlag     (o_zeroFlag),
    .o_carryFlag    (o_carryFlag),
    .o_signFlag     (o_signFlag),
    .o_overflowFlag (o_overflowFlag)
  );

  function automatic logic [3:0] dut_flags();
    return {o_zeroFlag, o_carryFlag, o_signFlag, o_overflowFlag};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // The write strobe must never stay high for two consecutive cycles.
  always @(negedge i_clk) begin
    if (o_rw) begin
      checks++;
      if (prev_rw) begin
        errors++;
        $display("FAIL rw_consecutive: got 1 expected 0 at %0t", $time);
      end
    end
    prev_rw <= o_rw;
  end

  function automatic int ovf(input int s);
    return (s > 127 || s < -128) ? 1 : 0;
  endfunction

  // Reference model: signed/unsigned integer arithmetic and closed-form shifts.
  task automatic model_op(input logic [8:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] res, output logic [3:0] flags, output int lat);
    int x, y, sa, sb, t, n, c, v, cin, r9;
    x = int'(a);
    y = int'(b);
    sa = (x > 127) ? x - 256 : x;
    sb = (y > 127) ? y - 256 : y;
    cin = int'(m_flags[2]);
    c = cin;
    v = int'(m_flags[0]);
    n = y % 8;
    t = x;
    lat = 1;
    case (int'(op))
      1: begin t = x + y;       c = (t > 255) ? 1 : 0; v = ovf(sa + sb); end
      2: begin t = x - y;       c = (t < 0) ? 1 : 0;   v = ovf(sa - sb); end
      3: begin t = x & y;       v = 0; end
      4: begin t = x | y;       v = 0; end
      5: begin t = x ^ y;       v = 0; end
      6: begin t = 255 - x;     v = 0; end
      7: begin t = x + y + cin; c = (t > 255) ? 1 : 0; v = ovf(sa + sb + cin); end
      8: begin t = x - y - cin; c = (t < 0) ? 1 : 0;   v = ovf(sa - sb - cin); end
      9, 10, 11, 12, 13, 14: begin
        lat = n + 1;
        if (n != 0) begin
          case (int'(op))
            9:  begin t = x << n; c = (t >> 8) & 1; end
            10: begin t = x >> n; c = (x >> (n - 1)) & 1; end
            11: begin t = sa >>> n; c = (x >> (n - 1)) & 1; end
            12: begin t = ((x << n) | (x >> (8 - n))) & 255; c = t & 1; end
            13: begin t = ((x >> n) | (x << (8 - n))) & 255; c = (t >> 7) & 1; end
            default: begin
              r9 = (cin << 8) | x;
              r9 = ((r9 << n) | (r9 >> (9 - n))) & 511;
              t = r9 & 255;
              c = r9 >> 8;
            end
          endcase
        end
      end
      default: lat = 0;
    endcase
    t = t & 255;
    res = t[7:0];
    if (lat != 0)
      m_flags = {(t == 0), c[0], t[7], v[0]};
    flags = m_flags;
  endtask

  // Issue one operation from an idle negedge and check its write-back.
  task automatic run_op(input string tag, input logic [8:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] addr, input logic [7:0] exp_res,
                        input logic [3:0] exp_flags, input int exp_lat);
    int cyc;
    chk({tag, "_ready_in"}, o_ready, 1);
    i_valid = 1'b1;
    i_aluOp = op;
    i_data1 = a;
    i_data2 = b;
    i_addrRw = addr;
    @(negedge i_clk);
    i_valid = 1'b0;
    if (exp_lat == 0) begin
      chk({tag, "_nop_rw"}, o_rw, 0);
      chk({tag, "_nop_ready"}, o_ready, 1);
      @(negedge i_clk);
      chk({tag, "_nop_rw2"}, o_rw, 0);
      chk({tag, "_nop_flags"}, dut_flags(), exp_flags);
    end else begin
      cyc = 1;
      while (!o_rw && cyc < 20) begin
        chk({tag, "_busy_ready"}, o_ready, 0);
        @(negedge i_clk);
        cyc++;
      end
      chk({tag, "_latency"}, cyc, exp_lat);
      chk({tag, "_data"}, o_dataOut, exp_res);
      chk({tag, "_addr"}, o_addrRw, addr);
      chk({tag, "_flags"}, dut_flags(), exp_flags);
      chk({tag, "_wb_ready"}, o_ready, 0);
      @(negedge i_clk);
      chk({tag, "_rw_after"}, o_rw, 0);
    end
  endtask

  task automatic model_and_run(input string tag, input logic [8:0] op, input logic [7:0] a,
                               input logic [7:0] b, input logic [2:0] addr);
    logic [7:0] r;
    logic [3:0] f;
    int l;
    model_op(op, a, b, r, f, l);
    run_op(tag, op, a, b, addr, r, f, l);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r1, r2;
    logic [3:0] f1, f2;
    int l1, l2, cyc;
    logic [8:0] rop;

    // Flags {Z,C,S,V}; entries run in order, so carry/overflow history matters.
    vecs[0]  = '{9'd1,   8'h7F, 8'h01, 3'd3, 8'h80, 4'b0011, 1};
    vecs[1]  = '{9'd2,   8'h05, 8'h05, 3'd1, 8'h00, 4'b1000, 1};
    vecs[2]  = '{9'd2,   8'h00, 8'h01, 3'd2, 8'hFF, 4'b0110, 1};
    vecs[3]  = '{9'd8,   8'h00, 8'h00, 3'd4, 8'hFF, 4'b0110, 1};
    vecs[4]  = '{9'd7,   8'hFF, 8'h00, 3'd7, 8'h00, 4'b1100, 1};
    vecs[5]  = '{9'd3,   8'hF0, 8'h0F, 3'd5, 8'h00, 4'b1100, 1};
    vecs[6]  = '{9'd0,   8'h12, 8'h34, 3'd6, 8'h00, 4'b1100, 0};
    vecs[7]  = '{9'd4,   8'h80, 8'h01, 3'd0, 8'h81, 4'b0110, 1};
    vecs[8]  = '{9'd5,   8'hAA, 8'hAA, 3'd1, 8'h00, 4'b1100, 1};
    vecs[9]  = '{9'd6,   8'h0F, 8'h00, 3'd2, 8'hF0, 4'b0110, 1};
    vecs[10] = '{9'd9,   8'h81, 8'h0B, 3'd3, 8'h08, 4'b0000, 4};
    vecs[11] = '{9'd9,   8'h55, 8'hF8, 3'd4, 8'h55, 4'b0000, 1};
    vecs[12] = '{9'd14,  8'h80, 8'h01, 3'd5, 8'h00, 4'b1100, 2};
    vecs[13] = '{9'd13,  8'h01, 8'h01, 3'd6, 8'h80, 4'b0110, 2};
    vecs[14] = '{9'd11,  8'h80, 8'h07, 3'd7, 8'hFF, 4'b0010, 8};
    vecs[15] = '{9'd10,  8'h80, 8'h07, 3'd0, 8'h01, 4'b0000, 8};
    vecs[16] = '{9'd12,  8'h81, 8'h01, 3'd1, 8'h03, 4'b0100, 2};
    vecs[17] = '{9'd1,   8'h80, 8'h80, 3'd2, 8'h00, 4'b1101, 1};
    vecs[18] = '{9'd10,  8'h02, 8'h01, 3'd3, 8'h01, 4'b0001, 2};
    vecs[19] = '{9'd15,  8'h11, 8'h22, 3'd4, 8'h00, 4'b0001, 0};
    vecs[20] = '{9'h1FF, 8'h11, 8'h22, 3'd5, 8'h00, 4'b0001, 0};
    vecs[21] = '{9'd7,   8'h7F, 8'h00, 3'd6, 8'h7F, 4'b0000, 1};

    // Reset held: idle, no write, everything cleared.
    @(negedge i_clk);
    chk("rst_ready", o_ready, 1);
    chk("rst_rw", o_rw, 0);
    chk("rst_flags", dut_flags(), 0);
    chk("rst_data", o_dataOut, 0);
    chk("rst_addr", o_addrRw, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) begin
      @(negedge i_clk);
      chk("rst_release_rw", o_rw, 0);
    end

    for (int i = 0; i < 22; i++) begin
      model_op(vecs[i].op, vecs[i].a, vecs[i].b, r1, f1, l1);
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].addr,
             vecs[i].res, vecs[i].flags, vecs[i].lat);
    end

    // i_valid held through a shift: second op only accepted after the write-back.
    model_op(9'd9, 8'h81, 8'h03, r1, f1, l1);
    model_op(9'd1, 8'h01, 8'h01, r2, f2, l2);
    chk("hold_ready_in", o_ready, 1);
    i_valid = 1'b1;
    i_aluOp = 9'd9;
    i_data1 = 8'h81;
    i_data2 = 8'h03;
    i_addrRw = 3'd2;
    @(negedge i_clk);
    i_aluOp = 9'd1;
    i_data1 = 8'h01;
    i_data2 = 8'h01;
    i_addrRw = 3'd6;
    cyc = 1;
    while (!o_rw && cyc < 20) begin
      @(negedge i_clk);
      cyc++;
    end
    chk("hold_lat1", cyc, l1);
    chk("hold_data1", o_dataOut, r1);
    chk("hold_addr1", o_addrRw, 2);
    chk("hold_flags1", dut_flags(), f1);
    @(negedge i_clk);
    chk("hold_gap_rw", o_rw, 0);
    chk("hold_gap_ready", o_ready, 1);
    @(negedge i_clk);
    i_valid = 1'b0;
    chk("hold_rw2", o_rw, 1);
    chk("hold_data2", o_dataOut, r2);
    chk("hold_addr2", o_addrRw, 6);
    chk("hold_flags2", dut_flags(), f2);
    @(negedge i_clk);
    chk("hold_rw_after", o_rw, 0);

    // Reset in the middle of a 7-step shift aborts it and clears the flags.
    model_and_run("pre_abort", 9'd1, 8'hFF, 8'h01, 3'd0);
    chk("abort_ready_in", o_ready, 1);
    i_valid = 1'b1;
    i_aluOp = 9'd10;
    i_data1 = 8'hFF;
    i_data2 = 8'h07;
    i_addrRw = 3'd5;
    @(negedge i_clk);
    i_valid = 1'b0;
    chk("abort_busy", o_ready, 0);
    @(negedge i_clk);
    @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    chk("abort_rw", o_rw, 0);
    chk("abort_ready", o_ready, 1);
    chk("abort_flags", dut_flags(), 0);
    chk("abort_data", o_dataOut, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    m_flags = 4'b0000;
    repeat (10) begin
      @(negedge i_clk);
      chk("abort_no_rw", o_rw, 0);
    end
    chk("abort_ready_after", o_ready, 1);
    chk("abort_flags_after", dut_flags(), 0);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0)
        rop = 9'($urandom_range(15, 511));
      else
        rop = 9'($urandom_range(0, 14));
      model_and_run($sformatf("rnd%0d", i), rop, 8'($urandom), 8'($urandom),
                    3'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
